// File: rtl/renode_axi_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : renode_axi_arbiter                                            |
// | Purpose  : 2:1 AXI arbiter in front of the Renode memory slave port.     |
// |            Read and write directions are arbitrated independently with   |
// |            round-robin fairness. Each direction allows one outstanding   |
// |            transaction. Optional watchdog: RENODE_AXI_ARB_WATCHDOG_EN.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
// Request vector layout, LSB first:
//   r_ready | ar_valid | ar{burst,size,len,addr,id} | b_ready | w_valid |
//   w{last,strb,data} | aw_valid | aw{burst,size,len,addr,id}
// Response vector layout, LSB first:
//   aw_ready | ar_ready | w_ready | b_valid | b{resp,id} | r_valid |
//   r{last,resp,data,id}
module renode_axi_arbiter #(
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  localparam int unsigned AX_W  = ID_W + ADDR_W + 13,
  localparam int unsigned WP_W  = DATA_W + DATA_W / 8 + 1,
  localparam int unsigned B_W   = ID_W + 2,
  localparam int unsigned RP_W  = ID_W + DATA_W + 3,
  localparam int unsigned REQ_W = 2 * AX_W + WP_W + 5,
  localparam int unsigned RSP_W = B_W + RP_W + 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REQ_W-1:0] s0_req_i,
  output logic [RSP_W-1:0] s0_resp_o,
  input  logic [REQ_W-1:0] s1_req_i,
  output logic [RSP_W-1:0] s1_resp_o,
  output logic [REQ_W-1:0] m_req_o,
  input  logic [RSP_W-1:0] m_resp_i,
  output logic             timeout_o
);

  localparam int unsigned REQ_R_READY  = 0;
  localparam int unsigned REQ_AR_VALID = 1;
  localparam int unsigned REQ_AR_LSB   = 2;
  localparam int unsigned REQ_B_READY  = 2 + AX_W;
  localparam int unsigned REQ_W_VALID  = 3 + AX_W;
  localparam int unsigned REQ_W_LSB    = 4 + AX_W;
  localparam int unsigned REQ_AW_VALID = 4 + AX_W + WP_W;
  localparam int unsigned REQ_AW_LSB   = 5 + AX_W + WP_W;
  localparam int unsigned RSP_AW_READY = 0;
  localparam int unsigned RSP_AR_READY = 1;
  localparam int unsigned RSP_W_READY  = 2;
  localparam int unsigned RSP_B_VALID  = 3;
  localparam int unsigned RSP_B_LSB    = 4;
  localparam int unsigned RSP_R_VALID  = 4 + B_W;
  localparam int unsigned RSP_R_LSB    = 5 + B_W;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_AW = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} w_state_e;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_DATA = 2'd2} r_state_e;

  w_state_e         w_state_q, w_state_d;
  r_state_e         r_state_q, r_state_d;
  logic             w_own_q, w_own_d, w_prio_q, w_prio_d;
  logic             r_own_q, r_own_d, r_prio_q, r_prio_d;
  logic [REQ_W-1:0] w_req, r_req;
  logic             aw_hs, w_last_hs, b_hs, b_err_hs;
  logic             ar_hs, r_beat_hs, r_last_hs, r_err_hs;
  logic             w_tout, r_tout, b_drain, r_drain;
  logic [B_W-1:0]   err_b;
  logic [RP_W-1:0]  err_r;
  logic             aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;
  logic [RSP_W-1:0] rsp_base;

  // Current owner's request for each direction
  assign w_req = w_own_q ? s1_req_i : s0_req_i;
  assign r_req = r_own_q ? s1_req_i : s0_req_i;

  assign aw_hs     = (w_state_q == W_AW) && w_req[REQ_AW_VALID] && m_resp_i[RSP_AW_READY];
  assign w_last_hs = (w_state_q == W_DATA) && w_req[REQ_W_VALID] && m_resp_i[RSP_W_READY]
                     && w_req[REQ_W_LSB];
  assign b_hs      = (w_state_q == W_RESP) && !w_tout && !b_drain && m_resp_i[RSP_B_VALID]
                     && w_req[REQ_B_READY];
  assign b_err_hs  = w_tout && w_req[REQ_B_READY];
  assign ar_hs     = (r_state_q == R_AR) && r_req[REQ_AR_VALID] && m_resp_i[RSP_AR_READY];
  assign r_beat_hs = (r_state_q == R_DATA) && !r_tout && !r_drain && m_resp_i[RSP_R_VALID]
                     && r_req[REQ_R_READY];
  assign r_last_hs = r_beat_hs && m_resp_i[RSP_R_LSB];
  assign r_err_hs  = r_tout && r_req[REQ_R_READY];

`ifdef RENODE_AXI_ARB_WATCHDOG_EN
  localparam int unsigned     CNT_W   = $clog2(TimeoutCycles + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TimeoutCycles);

  logic [CNT_W-1:0] w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;
  logic [ID_W-1:0]  w_id_q, w_id_d, r_id_q, r_id_d;
  logic             b_drain_q, b_drain_d, r_drain_q, r_drain_d, timeout_q, timeout_d;

  assign w_tout    = (w_state_q == W_RESP) && (w_cnt_q == CNT_MAX);
  assign r_tout    = (r_state_q == R_DATA) && (r_cnt_q == CNT_MAX);
  assign b_drain   = b_drain_q;
  assign r_drain   = r_drain_q;
  assign timeout_o = timeout_q;
  assign err_b     = {w_id_q, 2'b10};
  assign err_r     = {r_id_q, {DATA_W{1'b0}}, 2'b10, 1'b1};

  // Watchdog counters, stored IDs for the local error reply, drain and sticky flags
  always_comb begin
    w_cnt_d = '0;
    r_cnt_d = '0;
    if ((w_state_q == W_RESP) && !b_hs && !b_err_hs) w_cnt_d = w_tout ? w_cnt_q : w_cnt_q + 1'b1;
    if ((r_state_q == R_DATA) && !r_beat_hs && !r_err_hs) r_cnt_d = r_tout ? r_cnt_q : r_cnt_q + 1'b1;
    w_id_d = aw_hs ? w_req[REQ_AW_LSB+AX_W-ID_W +: ID_W] : w_id_q;
    r_id_d = ar_hs ? r_req[REQ_AR_LSB+AX_W-ID_W +: ID_W] : r_id_q;
    b_drain_d = b_drain_q;
    if (b_drain_q && m_resp_i[RSP_B_VALID]) b_drain_d = 1'b0;
    if (b_err_hs) b_drain_d = 1'b1;
    r_drain_d = r_drain_q;
    if (r_drain_q && m_resp_i[RSP_R_VALID] && m_resp_i[RSP_R_LSB]) r_drain_d = 1'b0;
    if (r_err_hs) r_drain_d = 1'b1;
    timeout_d = timeout_q | b_err_hs | r_err_hs;
  end

  // Watchdog state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_cnt_q <= '0; r_cnt_q <= '0; w_id_q <= '0; r_id_q <= '0;
      b_drain_q <= 1'b0; r_drain_q <= 1'b0; timeout_q <= 1'b0;
    end else begin
      w_cnt_q <= w_cnt_d; r_cnt_q <= r_cnt_d; w_id_q <= w_id_d; r_id_q <= r_id_d;
      b_drain_q <= b_drain_d; r_drain_q <= r_drain_d; timeout_q <= timeout_d;
    end
  end
`else
  assign w_tout    = 1'b0;
  assign r_tout    = 1'b0;
  assign b_drain   = 1'b0;
  assign r_drain   = 1'b0;
  assign timeout_o = 1'b0;
  assign err_b     = '0;
  assign err_r     = '0;
`endif

  // Write FSM next state: grant on IDLE, release after B
  always_comb begin
    w_state_d = w_state_q;
    w_own_d   = w_own_q;
    w_prio_d  = w_prio_q;
    case (w_state_q)
      W_IDLE: if (s0_req_i[REQ_AW_VALID] || s1_req_i[REQ_AW_VALID]) begin
        w_own_d   = (s0_req_i[REQ_AW_VALID] && s1_req_i[REQ_AW_VALID]) ? w_prio_q
                                                                        : s1_req_i[REQ_AW_VALID];
        w_state_d = W_AW;
      end
      W_AW:   if (aw_hs) w_state_d = W_DATA;
      W_DATA: if (w_last_hs) w_state_d = W_RESP;
      W_RESP: if (b_hs || b_err_hs) begin
        w_prio_d  = ~w_own_q;
        w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM next state: grant on IDLE, release after last R beat
  always_comb begin
    r_state_d = r_state_q;
    r_own_d   = r_own_q;
    r_prio_d  = r_prio_q;
    case (r_state_q)
      R_IDLE: if (s0_req_i[REQ_AR_VALID] || s1_req_i[REQ_AR_VALID]) begin
        r_own_d   = (s0_req_i[REQ_AR_VALID] && s1_req_i[REQ_AR_VALID]) ? r_prio_q
                                                                        : s1_req_i[REQ_AR_VALID];
        r_state_d = R_AR;
      end
      R_AR:   if (ar_hs) r_state_d = R_DATA;
      R_DATA: if (r_last_hs || r_err_hs) begin
        r_prio_d  = ~r_own_q;
        r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // FSM, owner and priority registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE; r_state_q <= R_IDLE;
      w_own_q <= 1'b0; w_prio_q <= 1'b0; r_own_q <= 1'b0; r_prio_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d; r_state_q <= r_state_d;
      w_own_q <= w_own_d; w_prio_q <= w_prio_d; r_own_q <= r_own_d; r_prio_q <= r_prio_d;
    end
  end

  // Slave-side request: owner payloads pass through, valids/readies gated by state
  always_comb begin
    m_req_o = '0;
    m_req_o[REQ_AW_LSB +: AX_W] = w_req[REQ_AW_LSB +: AX_W];
    m_req_o[REQ_W_LSB +: WP_W]  = w_req[REQ_W_LSB +: WP_W];
    m_req_o[REQ_AR_LSB +: AX_W] = r_req[REQ_AR_LSB +: AX_W];
    m_req_o[REQ_AW_VALID] = (w_state_q == W_AW) && w_req[REQ_AW_VALID];
    m_req_o[REQ_W_VALID]  = (w_state_q == W_DATA) && w_req[REQ_W_VALID];
    m_req_o[REQ_B_READY]  = b_drain || ((w_state_q == W_RESP) && !w_tout && w_req[REQ_B_READY]);
    m_req_o[REQ_AR_VALID] = (r_state_q == R_AR) && r_req[REQ_AR_VALID];
    m_req_o[REQ_R_READY]  = r_drain || ((r_state_q == R_DATA) && !r_tout && r_req[REQ_R_READY]);
  end

  // Requester-side responses: only the owner sees handshake signals
  always_comb begin
    aw_rdy = (w_state_q == W_AW) && m_resp_i[RSP_AW_READY];
    w_rdy  = (w_state_q == W_DATA) && m_resp_i[RSP_W_READY];
    b_vld  = w_tout || ((w_state_q == W_RESP) && !b_drain && m_resp_i[RSP_B_VALID]);
    ar_rdy = (r_state_q == R_AR) && m_resp_i[RSP_AR_READY];
    r_vld  = r_tout || ((r_state_q == R_DATA) && !r_drain && m_resp_i[RSP_R_VALID]);
    rsp_base = m_resp_i;
    rsp_base[RSP_AW_READY] = 1'b0;
    rsp_base[RSP_AR_READY] = 1'b0;
    rsp_base[RSP_W_READY]  = 1'b0;
    rsp_base[RSP_B_VALID]  = 1'b0;
    rsp_base[RSP_R_VALID]  = 1'b0;
    s0_resp_o = rsp_base;
    s1_resp_o = rsp_base;
    s0_resp_o[RSP_AW_READY] = !w_own_q && aw_rdy;
    s1_resp_o[RSP_AW_READY] =  w_own_q && aw_rdy;
    s0_resp_o[RSP_W_READY]  = !w_own_q && w_rdy;
    s1_resp_o[RSP_W_READY]  =  w_own_q && w_rdy;
    s0_resp_o[RSP_B_VALID]  = !w_own_q && b_vld;
    s1_resp_o[RSP_B_VALID]  =  w_own_q && b_vld;
    s0_resp_o[RSP_AR_READY] = !r_own_q && ar_rdy;
    s1_resp_o[RSP_AR_READY] =  r_own_q && ar_rdy;
    s0_resp_o[RSP_R_VALID]  = !r_own_q && r_vld;
    s1_resp_o[RSP_R_VALID]  =  r_own_q && r_vld;
    if (w_tout) begin
      if (w_own_q) s1_resp_o[RSP_B_LSB +: B_W] = err_b;
      else         s0_resp_o[RSP_B_LSB +: B_W] = err_b;
    end
    if (r_tout) begin
      if (r_own_q) s1_resp_o[RSP_R_LSB +: RP_W] = err_r;
      else         s0_resp_o[RSP_R_LSB +: RP_W] = err_r;
    end
  end

endmodule
`default_nettype wire

// File: doc/renode_axi_arbiter.md
# renode_axi_arbiter

Two-to-one AXI arbiter that shares the single Renode-backed memory slave port (`renode_memory` behind `renode_axi_if`) between two cluster masters, e.g. two `snitch_cluster_wrapper` wide ports. Read and write directions are arbitrated independently with round-robin fairness. Each direction allows one outstanding transaction, locked from address handshake to final response, so no ID remapping is needed. The block sits between the masters' `axi_connection_req_t`/`resp_t` structs and the `__REQ_TO_RENODE`/`__RENODE_TO_RESP` conversion in the testbench top.

## Interface
- `TimeoutCycles`, default 1024: watchdog limit in cycles; used only when `RENODE_AXI_ARB_WATCHDOG_EN` is defined.
- `clk_i`, in, 1: clock; all logic on its rising edge.
- `rst_i`, in, 1: reset, **synchronous, active-high**.
- `s0_req_i`, in, `axi_connection_req_t`: requester 0 AXI request.
- `s0_resp_o`, out, `axi_connection_resp_t`: requester 0 AXI response.
- `s1_req_i`, in, `axi_connection_req_t`: requester 1 AXI request.
- `s1_resp_o`, out, `axi_connection_resp_t`: requester 1 AXI response.
- `m_req_o`, out, `axi_connection_req_t`: request to the memory slave.
- `m_resp_i`, in, `axi_connection_resp_t`: response from the memory slave.
- `timeout_o`, out, 1: sticky watchdog flag.

## Operation
- Write FSM states:
  - `W_IDLE`: sample `aw_valid` of both requesters. On any request, register the owner `w_own` and go to `W_AW`.
  - `W_AW`: forward the owner's AW fields and `aw_valid` to `m_req_o`; return `m_resp_i.aw_ready` to the owner only. On handshake, go to `W_DATA`.
  - `W_DATA`: forward owner W and `w_valid`, return `w_ready`. On a handshake with `w_last=1`, go to `W_RESP`.
  - `W_RESP`: `m_req_o.b_ready` = owner `b_ready`; owner sees `b_valid` and B fields. On handshake, toggle `w_prio` to the non-owner and go to `W_IDLE`.
- Read FSM states:
  - `R_IDLE`: on any request, register `r_own` and go to `R_AR`.
  - `R_AR`: forward AR; on handshake, go to `R_DATA`.
  - `R_DATA`: route R beats and `r_ready`. On a handshake with `r_last=1`, toggle `r_prio` and go to `R_IDLE`.
- Arbitration:
  - Both requesters valid in IDLE: the requester indicated by the prio pointer wins.
  - Single requester: it wins regardless of the pointer, and the pointer does not move before completion.
- The non-owner, and both requesters while idle, see all `*_ready`/`*_valid` response signals at 0. The remaining response fields are passed through from `m_resp_i`.
- `m_req_o` valids and readies are 0 in any state where the table above does not drive them.
- The write and read FSMs are fully independent. Both may be active simultaneously, with the same or different owners.
- W beats arriving before the AW handshake are stalled (`w_ready=0`). This is AXI-legal.
- Response beats from the slave in an IDLE state are never acknowledged (`b_ready`/`r_ready` held 0).

## Timing
- Reset values: FSMs in IDLE; `w_prio`=`r_prio`=0; `w_own`=`r_own`=0; all valid/ready outputs 0; `timeout_o`=0; watchdog counters 0.
- Grant latency: a request first visible in IDLE at edge N is presented as `m_req_o.aw_valid`/`ar_valid` in the cycle after edge N (one-cycle latency).
- After grant, the address, data and response paths are combinational pass-through, with zero added latency per beat.
- Release: the final handshake at edge M puts the FSM in IDLE after M. The next grant becomes visible one cycle later. Minimum back-to-back spacing per direction is 2 idle-to-grant cycles.
- Reset mid-transaction: at the edge where `rst_i` is sampled high, all state and outputs return to reset values. In-flight beats are abandoned, and the slave side is expected to be reset concurrently.

## Configuration
- Macro: `RENODE_AXI_ARB_WATCHDOG_EN`.
- Defined:
  - A counter of width `$clog2(TimeoutCycles+1)` runs while in `W_RESP` or `R_DATA` and clears on each completed beat.
  - On reaching `TimeoutCycles`, the block drives a local error response to the owner: B with `resp=2'b10` (SLVERR), or a single R beat with `resp=2'b10` and `last=1`, held until the owner accepts it.
  - It then releases the direction and sets `timeout_o` sticky until reset.
  - Late slave responses for the abandoned transaction are absorbed: `b_ready`/`r_ready` are driven 1 until the matching last beat.
- Undefined: no counter; the block waits indefinitely; `timeout_o` is tied to 0.

## Test plan
- Single write from s0 (AW addr 0x1000, 4 beats, `w_last` on beat 4), B OKAY: s0 receives B; s1 sees no valid; `w_prio`=1 afterwards.
- s0 and s1 assert `ar_valid` in the same cycle, twice in a row: first grant goes to s0, second to s1. The respective R data (0xA5A5…, 0x5A5A…) reaches only the correct requester.
- s0 write and s1 read concurrently: both complete with no stall caused by the other direction. `m_req_o` shows AW and AR valid in the same cycle.
- `rst_i` pulsed in `W_DATA` after 2 of 4 beats: all valids are 0 after the edge and `w_prio`=0. A new s1 write then completes normally.
- Watchdog build with `TimeoutCycles`=8 and slave withholding B: s0 receives B SLVERR 8 cycles after entering `W_RESP`, and `timeout_o`=1. Non-watchdog build: the block stays in `W_RESP` and `timeout_o`=0.
